// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// The core side (master) issues requests; the unit (slave) returns HI/LO.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] RSdata_i;
    logic [WIDTH-1:0] RTdata_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] HI_o;
    logic [WIDTH-1:0] LO_o;

    modport master (
        output start_i, op_i, RSdata_i, RTdata_i,
        input  busy_o, done_o, HI_o, LO_o
    );

    modport slave (
        input  start_i, op_i, RSdata_i, RTdata_i,
        output busy_o, done_o, HI_o, LO_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Fixed latency: IDLE -> WIDTH CALC cycles -> FIX writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Signed ops work on magnitudes; op_i[0] marks the signed variants.
    assign rs_neg = bus.op_i[0] & bus.RSdata_i[WIDTH-1];
    assign rt_neg = bus.op_i[0] & bus.RTdata_i[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.RSdata_i : bus.RSdata_i;
    assign rt_mag = rt_neg ? -bus.RTdata_i : bus.RTdata_i;

    // Multiply: upper half accumulates, multiplier shifts out of the bottom.
    // Divide: upper half is the partial remainder, lower half the
    // dividend shifting up while quotient bits shift in.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, b_q} : '0);
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, b_q};

    // One shift-add or restoring-divide step.
    always_comb begin
        acc_step = acc;
        if (is_mul)
            acc_step = {add_sum, acc[WIDTH-1:1]};
        else if (rem_diff[WIDTH])
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    assign prod_fix = neg_lo ? -acc : acc;

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        hi_fix = '0;
        lo_fix = '0;
        if (is_mul) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi_fix = rs_q;
            lo_fix = '1;
        end else begin
            hi_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH]
                            : acc[2*WIDTH-1:WIDTH];
            lo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start_i) state_nx = CALC;
            CALC:    if (cnt == CNT_LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            is_mul   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            rs_q     <= '0;
            b_q      <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == FIX);
            if (state == IDLE && bus.start_i) begin
                cnt      <= '0;
                is_mul   <= ~bus.op_i[1];
                neg_lo   <= rs_neg ^ rt_neg;
                neg_hi   <= rs_neg;
                div_zero <= bus.op_i[1] & (bus.RTdata_i == '0);
                rs_q     <= bus.RSdata_i;
                b_q      <= bus.op_i[1] ? rt_mag : rs_mag;
                acc      <= {{WIDTH{1'b0}},
                             bus.op_i[1] ? rs_mag : rt_mag};
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= acc_step;
            end else if (state == FIX) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.HI_o   = hi_q;
    assign bus.LO_o   = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the pipelined MIPS core, sitting directly downstream of the register file in the execute stage. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers that MFHI/MFLO read. Each operation takes a fixed number of cycles. While `busy_o` is high, the hazard logic stalls later HI/LO readers.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Only 32 is verified.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request a new operation. Sampled only in IDLE.
- `op_i`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled with `start_i`.
- `RSdata_i`  in  WIDTH  rs operand: multiplicand or dividend.
- `RTdata_i`  in  WIDTH  rt operand: multiplier or divisor.
- `busy_o`  out  1  operation in progress.
- `done_o`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `HI_o`  out  WIDTH  HI register: product upper half or remainder.
- `LO_o`  out  WIDTH  LO register: product lower half or quotient.

## Operation
- States:
  - IDLE: on `start_i`, latch operands and `op_i`, clear the iteration counter, go to CALC.
  - CALC: one iteration per cycle. After `WIDTH` iterations go to FIX.
  - FIX: apply sign correction and the divide-by-zero override, write HI/LO, go to IDLE.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time.
  - Result signs are recorded: product sign = sign(rs) XOR sign(rt); quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - FIX negates in two's complement where required. The product is negated as a full 2·WIDTH value.
- Multiply: shift-add over a 2·WIDTH accumulator. Final HI = product[63:32], LO = product[31:0].
- Divide: restoring division, one quotient bit per cycle. LO = quotient, HI = remainder (truncating division).
- Divide by zero (divisor 0, DIV or DIVU): the iterations still run. FIX forces LO = all ones and HI = the original rs value, with no sign correction.
- Overflow case, DIV 0x80000000 / 0xFFFFFFFF: result wraps. LO = 0x80000000, HI = 0. No exception.
- `start_i` outside IDLE is ignored. Operands are not re-sampled.
- HI/LO change only at the FIX edge or on reset. They hold their value otherwise, including while `busy_o` is high.
- Reset, any time including mid-operation: state IDLE, HI = LO = 0, `busy_o` = 0, `done_o` = 0, internal accumulators cleared. The aborted operation produces no `done_o`.

## Timing
- Edge E0: `start_i` sampled high in IDLE.
- Edges E1..E32: the 32 CALC iterations.
- Edge E33: FIX writes HI/LO.
- `busy_o` is registered. It is high from after E0 through the cycle ending at E33, i.e. 33 cycles.
- `done_o` is registered. It is high for exactly the one cycle after E33, when the state is IDLE and `busy_o` = 0. The new HI/LO are visible in that same cycle.
- Fixed latency: 33 edges from accepted start to result, for every op and operand value, including divide by zero.
- Back-to-back: `start_i` high in the `done_o` cycle is accepted. The next `done_o` follows 34 cycles after the previous one.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done_o` exactly 33 edges after start, one cycle wide; `busy_o` high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21). Also MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100 / 7 -> LO=0x0000000E, HI=0x00000002. DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (−2) -> LO=0xFFFFFFFD, HI=0x00000001.
- DIVU 0x00001234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234 at the same latency. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULTU 5×6 and, during its busy period, pulse `start_i` with DIVU 9/3 -> second request ignored; HI=0, LO=30; exactly one `done_o`.
- Complete MULTU 5×6, then assert `rst_i` 10 cycles into a following DIVU 9/3:
  - immediately: `busy_o` = 0, HI = LO = 0; no `done_o` afterwards.
  - then release reset and start DIVU 9/3 -> LO=3, HI=0.
  - in its `done_o` cycle, start MULT 2×3 -> LO=6, HI=0 with the second `done_o` 34 cycles later.
